// File: rtl/cvxif_result_buffer_if.sv
// Result-buffer bundle: snooped issue handshake, PAU result port and core result port.
// Occupancy and overflow status ride along so a single modport carries everything.
interface cvxif_result_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              issue_valid;
    logic              issue_ready;
    logic              issue_resp_accept;
    logic              issue_resp_writeback;
    logic [31:0]       issue_req_instr;
    logic              issue_hold;

    logic              pau_result_valid;
    logic              pau_result_ready;
    logic [DATA_W-1:0] pau_result_data;

    logic              core_result_valid;
    logic              core_result_ready;
    logic [DATA_W-1:0] core_result_data;
    logic [4:0]        core_result_rd;
    logic              core_result_we;

    logic              overflow;
    logic [CW-1:0]     tag_count;
    logic [CW-1:0]     data_count;

    modport slave (
        input  issue_valid, issue_ready, issue_resp_accept, issue_resp_writeback,
        input  issue_req_instr, pau_result_valid, pau_result_data, core_result_ready,
        output issue_hold, pau_result_ready, core_result_valid, core_result_data,
        output core_result_rd, core_result_we, overflow, tag_count, data_count
    );

    modport master (
        output issue_valid, issue_ready, issue_resp_accept, issue_resp_writeback,
        output issue_req_instr, pau_result_valid, pau_result_data, core_result_ready,
        input  issue_hold, pau_result_ready, core_result_valid, core_result_data,
        input  core_result_rd, core_result_we, overflow, tag_count, data_count
    );
endinterface

// File: rtl/cvxif_result_buffer.sv
// Pairs in-order PAU results with snooped issue metadata (rd, writeback) and
// hands them to the core, absorbing core backpressure in two small FIFOs.
module cvxif_result_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    cvxif_result_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic       we;
        logic [4:0] rd;
    } tag_t;

    tag_t              r_tag_mem [DEPTH];
    logic [DATA_W-1:0] r_dat_mem [DEPTH];
    logic [PW-1:0]     r_tag_wp, r_tag_rp, r_dat_wp, r_dat_rp;
    logic [CW-1:0]     r_tag_cnt, r_dat_cnt;
    logic              r_pau_rdy;
    logic              r_ovf;

    logic              w_valid, w_pop;
    logic              w_tag_req, w_tag_full, w_tag_push;
    logic              w_dat_push;
    logic [CW-1:0]     w_tag_cnt_nxt, w_dat_cnt_nxt;

    assign w_valid    = (r_tag_cnt != '0) && (r_dat_cnt != '0);
    assign w_pop      = w_valid & bus.core_result_ready;
    assign w_tag_req  = bus.issue_valid & bus.issue_ready & bus.issue_resp_accept;
    assign w_tag_full = (r_tag_cnt == CW'(DEPTH));
    // A pop at full frees the head slot, so the concurrent push still fits.
    assign w_tag_push = w_tag_req & (~w_tag_full | w_pop);
    assign w_dat_push = bus.pau_result_valid & r_pau_rdy;

    always_comb begin
        w_tag_cnt_nxt = r_tag_cnt;
        w_dat_cnt_nxt = r_dat_cnt;
        case ({w_tag_push, w_pop})
            2'b10:   w_tag_cnt_nxt = r_tag_cnt + CW'(1);
            2'b01:   w_tag_cnt_nxt = r_tag_cnt - CW'(1);
            default: w_tag_cnt_nxt = r_tag_cnt;
        endcase
        case ({w_dat_push, w_pop})
            2'b10:   w_dat_cnt_nxt = r_dat_cnt + CW'(1);
            2'b01:   w_dat_cnt_nxt = r_dat_cnt - CW'(1);
            default: w_dat_cnt_nxt = r_dat_cnt;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag_wp  <= '0;
            r_tag_rp  <= '0;
            r_dat_wp  <= '0;
            r_dat_rp  <= '0;
            r_tag_cnt <= '0;
            r_dat_cnt <= '0;
            r_pau_rdy <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_tag_cnt <= w_tag_cnt_nxt;
            r_dat_cnt <= w_dat_cnt_nxt;
            // Registered ready means the PAU never sees a combinational path from the core.
            r_pau_rdy <= (w_dat_cnt_nxt < CW'(DEPTH));
            if (w_tag_req && w_tag_full && !w_pop) r_ovf <= 1'b1;
            if (w_tag_push) r_tag_wp <= r_tag_wp + PW'(1);
            if (w_dat_push) r_dat_wp <= r_dat_wp + PW'(1);
            if (w_pop) begin
                r_tag_rp <= r_tag_rp + PW'(1);
                r_dat_rp <= r_dat_rp + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tag_mem[i] <= '0;
                r_dat_mem[i] <= '0;
            end
        end else begin
            if (w_tag_push) r_tag_mem[r_tag_wp] <= '{we: bus.issue_resp_writeback, rd: bus.issue_req_instr[11:7]};
            if (w_dat_push) r_dat_mem[r_dat_wp] <= bus.pau_result_data;
        end
    end

    // Head fields are masked to zero whenever there is no complete pair to present.
    assign bus.core_result_valid = w_valid;
    assign bus.core_result_data  = w_valid ? r_dat_mem[r_dat_rp]    : '0;
    assign bus.core_result_rd    = w_valid ? r_tag_mem[r_tag_rp].rd : '0;
    assign bus.core_result_we    = w_valid & r_tag_mem[r_tag_rp].we;

    assign bus.issue_hold       = w_tag_full;
    assign bus.pau_result_ready = r_pau_rdy;
    assign bus.overflow         = r_ovf;
    assign bus.tag_count        = r_tag_cnt;
    assign bus.data_count       = r_dat_cnt;
endmodule

// File: tb/tb_cvxif_result_buffer.sv
// Scoreboard bench for cvxif_result_buffer: directed stimulus queues expected
// {data, rd, we}; a negedge monitor pops and compares on every handshake.
module tb_cvxif_result_buffer;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   ndeliv = 0;

    logic [37:0] exp_q [$];

    cvxif_result_buffer_if #(.DEPTH(4), .DATA_W(32)) bus ();

    cvxif_result_buffer #(.DEPTH(4), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rd);
        return {20'h0, rd, 7'b0110011};
    endfunction

    task automatic expect_res(input logic [31:0] d, input logic [4:0] rd, input logic we);
        exp_q.push_back({d, rd, we});
    endtask

    task automatic do_issue(input logic [31:0] instr, input logic wb);
        bus.issue_valid          = 1'b1;
        bus.issue_resp_accept    = 1'b1;
        bus.issue_resp_writeback = wb;
        bus.issue_req_instr      = instr;
        tick();
        bus.issue_valid       = 1'b0;
        bus.issue_resp_accept = 1'b0;
    endtask

    task automatic do_pau(input logic [31:0] d);
        int n = 0;
        while (!bus.pau_result_ready && n < 20) begin
            tick();
            n++;
        end
        if (!bus.pau_result_ready) chk("pau_ready_timeout", 32'(bus.pau_result_ready), 32'd1);
        bus.pau_result_valid = 1'b1;
        bus.pau_result_data  = d;
        tick();
        bus.pau_result_valid = 1'b0;
    endtask

    // Monitor: scoreboard pop on handshake, plus hold-stability during stalls.
    initial begin
        logic [37:0] e;
        logic [31:0] sd;
        logic [4:0]  srd;
        logic        swe;
        logic        stall;
        stall = 1'b0;
        sd = '0; srd = '0; swe = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("stall_valid", 32'(bus.core_result_valid), 32'd1);
                    chk("stall_data", bus.core_result_data, sd);
                    chk("stall_rd", 32'(bus.core_result_rd), 32'(srd));
                    chk("stall_we", 32'(bus.core_result_we), 32'(swe));
                end
                if (bus.core_result_valid && bus.core_result_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("res_data", bus.core_result_data, e[37:6]);
                        chk("res_rd", 32'(bus.core_result_rd), 32'(e[5:1]));
                        chk("res_we", 32'(bus.core_result_we), 32'(e[0]));
                        ndeliv++;
                    end
                end
                stall = bus.core_result_valid & ~bus.core_result_ready;
                sd  = bus.core_result_data;
                srd = bus.core_result_rd;
                swe = bus.core_result_we;
            end
        end
    end

    task automatic run_s1();
        chk("s1_tag_cnt0", 32'(bus.tag_count), 32'd0);
        do_issue(32'h00A0_0513, 1'b1);
        chk("s1_tag_cnt1", 32'(bus.tag_count), 32'd1);
        chk("s1_valid_pre", 32'(bus.core_result_valid), 32'd0);
        expect_res(32'hDEADBEEF, 5'd10, 1'b1);
        do_pau(32'hDEADBEEF);
        chk("s1_valid", 32'(bus.core_result_valid), 32'd1);
        chk("s1_data", bus.core_result_data, 32'hDEADBEEF);
        chk("s1_rd", 32'(bus.core_result_rd), 32'd10);
        chk("s1_we", 32'(bus.core_result_we), 32'd1);
        bus.core_result_ready = 1'b1;
        tick();
        bus.core_result_ready = 1'b0;
        chk("s1_tag_cnt_end", 32'(bus.tag_count), 32'd0);
        chk("s1_dat_cnt_end", 32'(bus.data_count), 32'd0);
        chk("s1_valid_end", 32'(bus.core_result_valid), 32'd0);
    endtask

    initial begin
        int base;
        rst = 1'b0;
        bus.issue_valid = 1'b0;
        bus.issue_ready = 1'b1;
        bus.issue_resp_accept = 1'b0;
        bus.issue_resp_writeback = 1'b0;
        bus.issue_req_instr = '0;
        bus.pau_result_valid = 1'b0;
        bus.pau_result_data = '0;
        bus.core_result_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.core_result_valid), 32'd0);
        chk("rst_pau_ready", 32'(bus.pau_result_ready), 32'd0);
        chk("rst_hold", 32'(bus.issue_hold), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_data", bus.core_result_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("pau_ready_after_rst", 32'(bus.pau_result_ready), 32'd1);

        // 1: single transaction
        run_s1();

        // 2: fill both FIFOs under stall, then drain in order
        for (int r = 1; r <= 4; r++) begin
            do_issue(mk(5'(r)), 1'b1);
            if (r == 3) chk("s2_hold_at3", 32'(bus.issue_hold), 32'd0);
        end
        chk("s2_hold", 32'(bus.issue_hold), 32'd1);
        chk("s2_tag_cnt", 32'(bus.tag_count), 32'd4);
        for (int r = 1; r <= 4; r++) begin
            expect_res(32'hA0 + 32'(r), 5'(r), 1'b1);
            do_pau(32'hA0 + 32'(r));
        end
        chk("s2_dat_cnt", 32'(bus.data_count), 32'd4);
        chk("s2_pau_ready", 32'(bus.pau_result_ready), 32'd0);
        chk("s2_head_rd", 32'(bus.core_result_rd), 32'd1);
        repeat (3) tick();
        bus.core_result_ready = 1'b1;
        repeat (4) tick();
        bus.core_result_ready = 1'b0;
        chk("s2_tag_cnt_end", 32'(bus.tag_count), 32'd0);
        chk("s2_dat_cnt_end", 32'(bus.data_count), 32'd0);
        chk("s2_pau_ready_end", 32'(bus.pau_result_ready), 32'd1);

        // 3: full tag FIFO, same-cycle push+pop, then overflow
        for (int r = 5; r <= 8; r++) do_issue(mk(5'(r)), (r != 7));
        expect_res(32'h200, 5'd5, 1'b1);
        do_pau(32'h200);
        bus.core_result_ready = 1'b1;
        do_issue(mk(5'd10), 1'b1);
        bus.core_result_ready = 1'b0;
        chk("s3_ovf_pushpop", 32'(bus.overflow), 32'd0);
        chk("s3_tag_cnt_pushpop", 32'(bus.tag_count), 32'd4);
        chk("s3_dat_cnt_pushpop", 32'(bus.data_count), 32'd0);
        do_issue(mk(5'd9), 1'b1);
        chk("s3_ovf", 32'(bus.overflow), 32'd1);
        chk("s3_tag_cnt_ovf", 32'(bus.tag_count), 32'd4);
        expect_res(32'h201, 5'd6, 1'b1);
        expect_res(32'h202, 5'd7, 1'b0);
        expect_res(32'h203, 5'd8, 1'b1);
        expect_res(32'h204, 5'd10, 1'b1);
        bus.core_result_ready = 1'b1;
        for (int i = 1; i <= 4; i++) do_pau(32'h200 + 32'(i));
        tick();
        bus.core_result_ready = 1'b0;
        chk("s3_tag_cnt_end", 32'(bus.tag_count), 32'd0);
        chk("s3_ovf_sticky", 32'(bus.overflow), 32'd1);

        // 4: orphan result waits for its tag
        expect_res(32'h1234, 5'd12, 1'b1);
        do_pau(32'h1234);
        chk("s4_valid_orphan", 32'(bus.core_result_valid), 32'd0);
        chk("s4_dat_cnt", 32'(bus.data_count), 32'd1);
        chk("s4_data_masked", bus.core_result_data, 32'd0);
        repeat (2) tick();
        chk("s4_valid_wait", 32'(bus.core_result_valid), 32'd0);
        do_issue(mk(5'd12), 1'b1);
        chk("s4_valid", 32'(bus.core_result_valid), 32'd1);
        chk("s4_data", bus.core_result_data, 32'h1234);
        bus.core_result_ready = 1'b1;
        tick();
        bus.core_result_ready = 1'b0;

        // 5: back-to-back streaming, one delivery per cycle
        chk("s5_pau_ready", 32'(bus.pau_result_ready), 32'd1);
        base = ndeliv;
        bus.core_result_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            expect_res(32'h300 + 32'(i), 5'(16 + i), i[0]);
            bus.issue_valid          = 1'b1;
            bus.issue_resp_accept    = 1'b1;
            bus.issue_resp_writeback = i[0];
            bus.issue_req_instr      = mk(5'(16 + i));
            bus.pau_result_valid     = 1'b1;
            bus.pau_result_data      = 32'h300 + 32'(i);
            tick();
        end
        bus.issue_valid       = 1'b0;
        bus.issue_resp_accept = 1'b0;
        bus.pau_result_valid  = 1'b0;
        tick();
        bus.core_result_ready = 1'b0;
        chk("s5_deliveries", 32'(ndeliv - base), 32'd10);
        chk("s5_tag_cnt", 32'(bus.tag_count), 32'd0);
        chk("s5_dat_cnt", 32'(bus.data_count), 32'd0);

        // 6: asynchronous reset mid-stall discards queued entries
        do_issue(mk(5'd3), 1'b1);
        do_issue(mk(5'd4), 1'b0);
        do_pau(32'h55);
        do_pau(32'h66);
        chk("s6_valid_pre", 32'(bus.core_result_valid), 32'd1);
        chk("s6_dat_cnt_pre", 32'(bus.data_count), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("s6_valid", 32'(bus.core_result_valid), 32'd0);
        chk("s6_tag_cnt", 32'(bus.tag_count), 32'd0);
        chk("s6_dat_cnt", 32'(bus.data_count), 32'd0);
        chk("s6_ovf", 32'(bus.overflow), 32'd0);
        chk("s6_pau_ready", 32'(bus.pau_result_ready), 32'd0);
        chk("s6_data", bus.core_result_data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();
        run_s1();

        repeat (2) tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
